// File: rtl/imm_ext_arbiter_if.sv
// Requester / consumer bundle for the shared immediate-extension unit.
// master: requesters plus result consumer; slave: the arbiter itself.
interface imm_ext_arbiter_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             req0_i;
  logic [1:0]       mode0_i;
  logic [IN_W-1:0]  data0_i;
  logic             gnt0_o;
  logic             req1_i;
  logic [1:0]       mode1_i;
  logic [IN_W-1:0]  data1_i;
  logic             gnt1_o;
  logic             vld_o;
  logic             id_o;
  logic [OUT_W-1:0] data_o;
  logic             ack_i;

  modport master (
    output req0_i, mode0_i, data0_i, req1_i, mode1_i, data1_i, ack_i,
    input  gnt0_o, gnt1_o, vld_o, id_o, data_o
  );

  modport slave (
    input  req0_i, mode0_i, data0_i, req1_i, mode1_i, data1_i, ack_i,
    output gnt0_o, gnt1_o, vld_o, id_o, data_o
  );
endinterface

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one registered immediate-extension unit
// between decode (requester 0) and the branch-target unit (requester 1).
// A single output register holds each result until the consumer acks it;
// ack and a new grant in the same cycle reload it back-to-back.
module imm_ext_arbiter #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  imm_ext_arbiter_if.slave  bus
);

  localparam int EXT_W = OUT_W - IN_W;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             ptr;
  logic             id_q;
  logic [OUT_W-1:0] data_q;
  logic             free;
  logic             gnt0, gnt1, any_gnt, winner;
  logic [1:0]       win_mode;
  logic [IN_W-1:0]  win_data;

  // Four extension modes; branch offset is sign extend then << 2 truncated.
  function automatic logic [OUT_W-1:0] ext(input logic [1:0] m,
                                           input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] sx;
    sx = {{EXT_W{d[IN_W-1]}}, d};
    case (m)
      2'b00:   ext = sx;
      2'b01:   ext = {{EXT_W{1'b0}}, d};
      2'b10:   ext = {d, {EXT_W{1'b0}}};
      default: ext = sx << 2;
    endcase
  endfunction

  // Grant logic: only when the slot frees this cycle and out of reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    free = (state == EMPTY) | bus.ack_i;
    if (rst_i && free) begin
      if (bus.req0_i && bus.req1_i) begin
        gnt0 = ~ptr;
        gnt1 = ptr;
      end else begin
        gnt0 = bus.req0_i;
        gnt1 = bus.req1_i;
      end
    end
    any_gnt  = gnt0 | gnt1;
    winner   = gnt1;
    win_mode = gnt1 ? bus.mode1_i : bus.mode0_i;
    win_data = gnt1 ? bus.data1_i : bus.data0_i;
  end

  // Next state: a grant always fills, an ack without a grant drains.
  always_comb begin
    state_nxt = state;
    if (any_gnt)
      state_nxt = FULL;
    else if (state == FULL && bus.ack_i)
      state_nxt = EMPTY;
  end

  // Result register, owner id, round-robin pointer and state.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state  <= EMPTY;
      ptr    <= 1'b0;
      id_q   <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (any_gnt) begin
        data_q <= ext(win_mode, win_data);
        id_q   <= winner;
        ptr    <= ~winner;
      end
    end
  end

  assign bus.gnt0_o = gnt0;
  assign bus.gnt1_o = gnt1;
  assign bus.vld_o  = (state == FULL);
  assign bus.id_o   = id_q;
  assign bus.data_o = data_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed test-plan steps followed by randomized traffic, all checked
// against a transaction-level reference model of the arbiter.
module tb_imm_ext_arbiter;
  logic clk_i = 1'b0;
  logic rst_i;

  imm_ext_arbiter_if #(.IN_W(16), .OUT_W(32)) bus ();

  imm_ext_arbiter #(.IN_W(16), .OUT_W(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit          m_vld;
  bit          m_id;
  bit   [31:0] m_data;
  int          m_prio;   // requester favoured when both ask
  int          m_win;    // -1: no grant this cycle

  function automatic bit [31:0] ref_ext(input int mode, input bit [15:0] d);
    int s;
    s = int'($signed(d));
    case (mode)
      0:       return 32'(s);
      1:       return 32'(d);
      2:       return 32'(d) * 32'd65536;
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic chk(input string tag, input bit [31:0] obs, input bit [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Predict grant at negedge, apply edge, then check registered outputs.
  task automatic cycle();
    @(negedge clk_i);
    m_win = -1;
    if (rst_i && (!m_vld || bus.ack_i)) begin
      if (bus.req0_i && bus.req1_i) m_win = m_prio;
      else if (bus.req0_i)          m_win = 0;
      else if (bus.req1_i)          m_win = 1;
    end
    chk("gnt0", 32'(bus.gnt0_o), 32'(m_win == 0));
    chk("gnt1", 32'(bus.gnt1_o), 32'(m_win == 1));
    @(posedge clk_i);
    if (!rst_i) begin
      m_vld = 0; m_id = 0; m_data = 0; m_prio = 0;
    end else if (m_win == 0) begin
      m_vld = 1; m_id = 0; m_data = ref_ext(int'(bus.mode0_i), bus.data0_i); m_prio = 1;
    end else if (m_win == 1) begin
      m_vld = 1; m_id = 1; m_data = ref_ext(int'(bus.mode1_i), bus.data1_i); m_prio = 0;
    end else if (bus.ack_i && m_vld) begin
      m_vld = 0;
    end
    #1;
    chk("vld", 32'(bus.vld_o), 32'(m_vld));
    chk("id", 32'(bus.id_o), 32'(m_id));
    chk("data", bus.data_o, m_data);
  endtask

  task automatic drive(input bit r0, input bit [1:0] md0, input bit [15:0] d0,
                       input bit r1, input bit [1:0] md1, input bit [15:0] d1,
                       input bit ack);
    bus.req0_i = r0; bus.mode0_i = md0; bus.data0_i = d0;
    bus.req1_i = r1; bus.mode1_i = md1; bus.data1_i = d1;
    bus.ack_i  = ack;
  endtask

  initial begin
    bit [31:0] held;
    m_vld = 0; m_id = 0; m_data = 0; m_prio = 0; m_win = -1;

    // reset with both requesting
    rst_i = 1'b0;
    drive(1, 2'b00, 16'h0001, 1, 2'b00, 16'h0002, 1);
    cycle();
    cycle();
    chk("rst_vld", 32'(bus.vld_o), 32'd0);
    chk("rst_data", bus.data_o, 32'h0);
    chk("rst_gnt", {30'd0, bus.gnt1_o, bus.gnt0_o}, 32'd0);

    // release: round robin starting at requester 0
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_id", 32'(bus.id_o), 32'(i % 2));
      chk("rr_data", bus.data_o, (i % 2) ? 32'h2 : 32'h1);
    end

    // all four modes from requester 0 alone
    for (int m = 0; m < 4; m++) begin
      drive(1, 2'(m), 16'h8004, 0, 2'b00, 16'h0, 1);
      cycle();
      case (m)
        0: chk("mode00", bus.data_o, 32'hFFFF8004);
        1: chk("mode01", bus.data_o, 32'h00008004);
        2: chk("mode10", bus.data_o, 32'h80040000);
        default: chk("mode11", bus.data_o, 32'hFFFE0010);
      endcase
      chk("mode_vld", 32'(bus.vld_o), 32'd1);
    end

    // backpressure on a requester-1 result
    drive(0, 2'b00, 16'h0, 1, 2'b11, 16'h7FFF, 1);
    cycle();
    chk("bp_grant", bus.data_o, 32'h0001FFFC);
    drive(1, 2'b01, 16'h1234, 0, 2'b00, 16'h0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold", bus.data_o, 32'h0001FFFC);
    end
    bus.ack_i = 1'b1;
    #1;
    chk("b2b_gnt0", 32'(bus.gnt0_o), 32'd1);
    cycle();
    chk("b2b_data", bus.data_o, 32'h00001234);
    chk("b2b_vld", 32'(bus.vld_o), 32'd1);

    // drain
    drive(0, 2'b00, 16'h0, 0, 2'b00, 16'h0, 1);
    cycle();
    chk("drain_vld", 32'(bus.vld_o), 32'd0);
    chk("drain_data", bus.data_o, 32'h00001234);

    // reset while full; pointer was left favouring requester 1
    drive(1, 2'b01, 16'h00AA, 0, 2'b00, 16'h0, 1);
    cycle();
    bus.ack_i = 1'b0;
    cycle();
    rst_i = 1'b0;
    cycle();
    chk("rf_vld", 32'(bus.vld_o), 32'd0);
    chk("rf_data", bus.data_o, 32'h0);
    rst_i = 1'b1;
    drive(1, 2'b01, 16'h0055, 1, 2'b01, 16'h0066, 1);
    cycle();
    chk("rf_ptr", 32'(bus.id_o), 32'd0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rst_i = ($urandom_range(0, 49) != 0);
      drive($urandom_range(0, 1) == 1, 2'($urandom), 16'($urandom),
            $urandom_range(0, 1) == 1, 2'($urandom), 16'($urandom),
            $urandom_range(0, 2) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
